banzai_axil_driver: RTL

// - AXI-Lite initiator for the Bayesian-machine controller's slave port.
// - Converts single-beat commands into AXI-Lite traffic: likelihood-memory word write,

---
 rtl/banzai_axil_driver.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/banzai_axil_driver.sv
// banzai_axil_driver: single-outstanding AXI-Lite initiator for the Bayesian controller.
// Optional bus watchdog is enabled by defining BANZAI_DRV_TIMEOUT_EN.
module banzai_axil_driver #(
  parameter logic [31:0] REG_BASE       = 32'h2000,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [35:0] cmd_obs,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] aw_addr,
  output logic        aw_valid,
  input  logic        aw_ready,
  output logic [31:0] w_data,
  output logic [3:0]  w_strb,
  output logic        w_valid,
  input  logic        w_ready,
  input  logic [1:0]  b_resp,
  input  logic        b_valid,
  output logic        b_ready,
  output logic [31:0] ar_addr,
  output logic        ar_valid,
  input  logic        ar_ready,
  input  logic [31:0] r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_valid,
  output logic        r_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_RESP, S_RESP
  } state_t;

  state_t      r_state, w_next;
  logic        r_infer;
  logic [1:0]  r_step;
  logic [26:0] r_obs;
  logic        r_aw_done, r_w_done;
  logic        w_aw_hs, w_w_hs, w_wr_done, w_tmo;
  logic [8:0]  w_next_o;

  assign cmd_ready  = (r_state == S_IDLE);
  assign b_ready    = (r_state == S_WR_RESP);
  assign r_ready    = (r_state == S_RD_RESP);
  assign resp_valid = (r_state == S_RESP);
  assign w_strb     = 4'hF;

  assign w_aw_hs   = aw_valid & aw_ready;
  assign w_w_hs    = w_valid & w_ready;
  assign w_wr_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

  // r_obs holds O2..O4; O1 goes out straight from the command
  always_comb begin
    w_next_o = r_obs[26:18];
    unique case (r_step)
      2'd0:    w_next_o = r_obs[8:0];
      2'd1:    w_next_o = r_obs[17:9];
      default: w_next_o = r_obs[26:18];
    endcase
  end

`ifdef BANZAI_DRV_TIMEOUT_EN
  logic [15:0] r_tmo;
  logic        w_busy;
  assign w_busy = (r_state == S_WR) || (r_state == S_WR_RESP) ||
                  (r_state == S_RD) || (r_state == S_RD_RESP);
  assign w_tmo  = w_busy && (r_tmo == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_tmo <= '0;
    else if (!w_busy || w_next != r_state) r_tmo <= '0;
    else                              r_tmo <= r_tmo + 16'd1;
  end
`else
  // no watchdog: the driver waits on the slave forever
  assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (cmd_valid) begin
        unique case (cmd_op)
          2'd0, 2'd2: w_next = S_WR;
          2'd1:       w_next = S_RD;
          default:    w_next = S_RESP;
        endcase
      end
      S_WR:      if (w_wr_done) w_next = S_WR_RESP;
      S_WR_RESP: if (b_valid) begin
        if (!r_infer)           w_next = S_RESP;
        else if (r_step == 2'd3) w_next = S_RD;
        else                    w_next = S_WR;
      end
      S_RD:      if (ar_ready) w_next = S_RD_RESP;
      S_RD_RESP: if (r_valid) w_next = S_RESP;
      S_RESP:    if (resp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (w_tmo) w_next = S_RESP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      ar_valid  <= 1'b0;
      aw_addr   <= '0;
      w_data    <= '0;
      ar_addr   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      r_infer   <= 1'b0;
      r_step    <= '0;
      r_obs     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_tmo) begin
        aw_valid  <= 1'b0;
        w_valid   <= 1'b0;
        ar_valid  <= 1'b0;
        resp_data <= '0;
        resp_err  <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: if (cmd_valid) begin
            r_infer   <= (cmd_op == 2'd2);
            r_step    <= '0;
            r_obs     <= cmd_obs[35:9];
            resp_err  <= (cmd_op == 2'd3);
            resp_data <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            unique case (cmd_op)
              2'd0: begin
                aw_addr  <= cmd_addr & 32'hFFFF_FFFC;
                w_data   <= cmd_data;
                aw_valid <= 1'b1;
                w_valid  <= 1'b1;
              end
              2'd1: begin
                ar_addr  <= cmd_addr & 32'hFFFF_FFFC;
                ar_valid <= 1'b1;
              end
              2'd2: begin
                aw_addr  <= REG_BASE + 32'd12;
                w_data   <= {23'd0, cmd_obs[8:0]};
                aw_valid <= 1'b1;
                w_valid  <= 1'b1;
              end
              default: ;
            endcase
          end
          S_WR: begin
            if (w_aw_hs) begin
              aw_valid  <= 1'b0;
              r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
              w_valid  <= 1'b0;
              r_w_done <= 1'b1;
            end
          end
          S_WR_RESP: if (b_valid) begin
            resp_err  <= resp_err | (b_resp != 2'b00);
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (r_infer && r_step != 2'd3) begin
              r_step   <= r_step + 2'd1;
              aw_addr  <= REG_BASE + 32'd16 + {28'd0, r_step, 2'b00};
              w_data   <= {23'd0, w_next_o};
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
            end else if (r_infer) begin
              ar_addr  <= REG_BASE;
              ar_valid <= 1'b1;
            end
          end
          S_RD: if (ar_ready) ar_valid <= 1'b0;
          S_RD_RESP: if (r_valid) begin
            resp_data <= r_data;
            resp_err  <= resp_err | (r_resp != 2'b00);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
